cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) among the functional units that complete instructions and broadcast results to the ROB and reservation stations.
- Round-robin selection of one completing requester per cycle.
- Winner's tag/data/branch info is registered onto the Cdb_* outputs, which the ROB samples.
- After broadcasting a taken branch, grants are withheld for a fixed hold window while the ROB flushes and the units squash their requests.

---
 rtl/rob_pkg.sv | 25 ++
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter_rr_picker.sv | 29 ++
 rtl/cdb_arbiter.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Constants, state encoding and CDB payload layout shared by the arbiter, ROB and reservation stations.
package rob_pkg;

   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int NUM_FU = 4;

   localparam int REQ_INT = 0;
   localparam int REQ_MUL = 1;
   localparam int REQ_LS  = 2;
   localparam int REQ_BR  = 3;

   typedef enum logic [0:0] {
      ARB_S_ARB  = 1'b0,
      ARB_S_HOLD = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic              branch;
      logic              branch_taken;
   } cdb_payload_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant handshake plus CDB broadcast bus between completing units and the arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_REQ = rob_pkg::NUM_FU,
   parameter int TAG_W   = rob_pkg::TAG_W,
   parameter int DATA_W  = rob_pkg::DATA_W
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*TAG_W-1:0]  req_tag;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_branch;
   logic [NUM_REQ-1:0]        req_branch_taken;
   logic [NUM_REQ-1:0]        req_grant;

   logic                      Cdb_valid;
   logic [TAG_W-1:0]          Cdb_rd_tag;
   logic [DATA_W-1:0]         Cdb_data;
   logic                      Cdb_branch;
   logic                      Cdb_branch_taken;

   modport master (
      output req_valid, req_tag, req_data, req_branch, req_branch_taken,
      input  req_grant, Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken
   );

   modport slave (
      input  req_valid, req_tag, req_data, req_branch, req_branch_taken,
      output req_grant, Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken
   );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational rotating-start picker: first set request at or after start, wrapping modulo N.
module rr_picker #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] start,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] idx
);

   always_comb begin
      int   pos;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(start) + k) % N;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = PTR_W'(pos);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a registered broadcast stage and a post-flush grant hold.
// Optional per-unit statistics counters are built when CDB_ARB_STATS_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_S_ARB  | normal round-robin arbitration, one grant per cycle
// ARB_S_HOLD | taken branch broadcast; grants withheld for FLUSH_HOLD cycles
module cdb_arbiter #(
   parameter int NUM_REQ    = rob_pkg::NUM_FU,
   parameter int TAG_W      = rob_pkg::TAG_W,
   parameter int DATA_W     = rob_pkg::DATA_W,
   parameter int FLUSH_HOLD = 2
) (
   input  logic          clock,
   input  logic          reset,
   cdb_arbiter_if.slave  bus,
   output logic          arb_busy
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] stat_grant_cnt,
   output logic [NUM_REQ*16-1:0] stat_stall_cnt,
   output logic [15:0]           stat_flush_cnt
`endif
);
   import rob_pkg::*;

   localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

   arb_state_e         state, state_nxt;
   logic [3:0]         hold_cnt, hold_nxt;
   logic [PTR_W-1:0]   rr_ptr, ptr_nxt, win_idx;
   logic [NUM_REQ-1:0] pick_grant, grant;
   logic               grant_any, take_flush;

   rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .req   (bus.req_valid),
      .start (rr_ptr),
      .grant (pick_grant),
      .idx   (win_idx)
   );

   assign grant         = (state == ARB_S_ARB && !reset) ? pick_grant : '0;
   assign bus.req_grant = grant;
   assign grant_any     = |grant;
   assign take_flush    = grant_any & bus.req_branch[win_idx] & bus.req_branch_taken[win_idx];
   assign ptr_nxt       = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
   assign arb_busy      = (state == ARB_S_HOLD);

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      case (state)
         ARB_S_ARB: begin
            if (take_flush) begin
               state_nxt = ARB_S_HOLD;
               hold_nxt  = HOLD_INIT;
            end
         end
         ARB_S_HOLD: begin
            if (hold_cnt == 4'd1) begin
               state_nxt = ARB_S_ARB;
               hold_nxt  = 4'd0;
            end else begin
               hold_nxt  = hold_cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = ARB_S_ARB;
            hold_nxt  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ARB_S_ARB;
         hold_cnt <= 4'd0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         if (grant_any) rr_ptr <= ptr_nxt;
      end
   end

   // Payload holds its last value on idle cycles; consumers qualify with Cdb_valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.Cdb_valid        <= 1'b0;
         bus.Cdb_rd_tag       <= '0;
         bus.Cdb_data         <= '0;
         bus.Cdb_branch       <= 1'b0;
         bus.Cdb_branch_taken <= 1'b0;
      end else begin
         bus.Cdb_valid <= grant_any;
         if (grant_any) begin
            bus.Cdb_rd_tag       <= bus.req_tag[win_idx*TAG_W +: TAG_W];
            bus.Cdb_data         <= bus.req_data[win_idx*DATA_W +: DATA_W];
            bus.Cdb_branch       <= bus.req_branch[win_idx];
            bus.Cdb_branch_taken <= bus.req_branch[win_idx] & bus.req_branch_taken[win_idx];
         end
      end
   end

`ifdef CDB_ARB_STATS_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      logic [15:0] g_cnt, s_cnt;
      always_ff @(posedge clock) begin
         if (reset) begin
            g_cnt <= 16'd0;
            s_cnt <= 16'd0;
         end else begin
            if (grant[i] && g_cnt != 16'hFFFF) g_cnt <= g_cnt + 16'd1;
            if (bus.req_valid[i] && !grant[i] && s_cnt != 16'hFFFF) s_cnt <= s_cnt + 16'd1;
         end
      end
      assign stat_grant_cnt[i*16 +: 16] = g_cnt;
      assign stat_stall_cnt[i*16 +: 16] = s_cnt;
   end

   logic [15:0] f_cnt;
   always_ff @(posedge clock) begin
      if (reset)                                 f_cnt <= 16'd0;
      else if (take_flush && f_cnt != 16'hFFFF)  f_cnt <= f_cnt + 16'd1;
   end
   assign stat_flush_cnt = f_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter: per-cycle stimulus rows with hand-computed grants and CDB contents.
module tb_cdb_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic arb_busy;

   always #5 clock = ~clock;

   cdb_arbiter_if #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32)) bus ();

`ifdef CDB_ARB_STATS_EN
   logic [63:0] stat_grant_cnt, stat_stall_cnt;
   logic [15:0] stat_flush_cnt;
`endif

   cdb_arbiter #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32), .FLUSH_HOLD(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .arb_busy       (arb_busy)
`ifdef CDB_ARB_STATS_EN
      ,
      .stat_grant_cnt (stat_grant_cnt),
      .stat_stall_cnt (stat_stall_cnt),
      .stat_flush_cnt (stat_flush_cnt)
`endif
   );

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic [3:0] br;
      logic [3:0] tk;
      logic [3:0] g;
      logic       cv;
      int         cu;   // unit whose payload must sit on the CDB, -1 = don't care
      logic       cbr;
      logic       cbt;
      logic       busy;
   } vec_t;

   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   logic [4:0]  unit_tag  [4] = '{5'd1, 5'd2, 5'd7, 5'd12};
   logic [31:0] unit_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h3333_3333};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] br, input logic [3:0] tk,
                      input logic [3:0] g, input logic cv, input int cu, input logic cbr,
                      input logic cbt, input logic busy);
      vec_t t;
      t.rst = rst; t.v = v; t.br = br; t.tk = tk; t.g = g;
      t.cv = cv; t.cu = cu; t.cbr = cbr; t.cbt = cbt; t.busy = busy;
      vecs.push_back(t);
   endtask

   task automatic apply(input vec_t t, input int row);
      @(negedge clock);
      reset                = t.rst;
      bus.req_valid        = t.v;
      bus.req_branch       = t.br;
      bus.req_branch_taken = t.tk;
      #1;
      chk($sformatf("row%0d grant", row), 32'(bus.req_grant), 32'(t.g));
      chk($sformatf("row%0d cdb_valid", row), 32'(bus.Cdb_valid), 32'(t.cv));
      chk($sformatf("row%0d arb_busy", row), 32'(arb_busy), 32'(t.busy));
      if (t.cu >= 0) begin
         chk($sformatf("row%0d cdb_tag", row), 32'(bus.Cdb_rd_tag), 32'(unit_tag[t.cu]));
         chk($sformatf("row%0d cdb_data", row), bus.Cdb_data, unit_data[t.cu]);
         chk($sformatf("row%0d cdb_branch", row), 32'(bus.Cdb_branch), 32'(t.cbr));
         chk($sformatf("row%0d cdb_taken", row), 32'(bus.Cdb_branch_taken), 32'(t.cbt));
      end
   endtask

   initial begin
      vec_t t;
      bus.req_valid        = '0;
      bus.req_branch       = '0;
      bus.req_branch_taken = '0;
      for (int i = 0; i < 4; i++) begin
         bus.req_tag[i*5 +: 5]    = unit_tag[i];
         bus.req_data[i*32 +: 32] = unit_data[i];
      end

      //   rst v        br       tk       g        cv  cu  cbr  cbt  busy
      add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, -1, 0, 0, 0);  // unit 2 alone
      add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1,  2, 0, 0, 0);
      add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0,  2, 0, 0, 0);  // idle holds payload
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, -1, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0, -1, 0, 0, 0);  // full rate from ptr 0
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1,  0, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1,  1, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1,  2, 0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1,  3, 0, 0, 0);
      add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1,  0, 0, 0, 0);
      add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0,  0, 0, 0, 0);
      add(0, 4'b1011, 4'b1000, 4'b1000, 4'b1000, 1,  2, 0, 0, 0);  // taken branch, cycle N
      add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1,  3, 1, 1, 1);  // N+1
      add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0,  3, 1, 1, 1);  // N+2
      add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 0,  3, 1, 1, 0);  // N+3 resumes
      add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1,  0, 0, 0, 0);
      add(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1,  1, 0, 0, 0);  // not-taken branch
      add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1,  3, 1, 0, 0);
      add(0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1,  0, 0, 0, 0);  // taken without branch
      add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1,  3, 0, 0, 0);
      add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1,  0, 0, 0, 0);
      add(0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0,  0, 0, 0, 0);  // taken branch again
      add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1,  3, 1, 1, 1);
      add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0,  3, 1, 1, 1);  // reset at hold_cnt=1
      add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, -1, 0, 0, 0);
      add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1,  1, 0, 0, 0);

      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      chk("reset grant", 32'(bus.req_grant), 32'h0);
      chk("reset cdb_valid", 32'(bus.Cdb_valid), 32'h0);
      chk("reset cdb_tag", 32'(bus.Cdb_rd_tag), 32'h0);
      chk("reset cdb_data", bus.Cdb_data, 32'h0);
      chk("reset cdb_branch", 32'(bus.Cdb_branch), 32'h0);
      chk("reset cdb_taken", 32'(bus.Cdb_branch_taken), 32'h0);
      chk("reset arb_busy", 32'(arb_busy), 32'h0);

      for (int r = 0; r < vecs.size(); r++) apply(vecs[r], r + 1);

`ifdef CDB_ARB_STATS_EN
      vecs.delete();
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1,  1, 0, 0, 0);
      add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 0, -1, 0, 0, 0);  // unit 1 stalls
      add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1,  0, 0, 0, 0);
      add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1,  1, 0, 0, 0);  // ptr 2: unit 1 stalls again
      add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1,  0, 0, 0, 0);
      for (int r = 0; r < vecs.size(); r++) apply(vecs[r], 100 + r);
      chk("stat grant0", 32'(stat_grant_cnt[15:0]), 32'd2);
      chk("stat grant1", 32'(stat_grant_cnt[31:16]), 32'd1);
      chk("stat stall1", 32'(stat_stall_cnt[31:16]), 32'd2);
      chk("stat stall0", 32'(stat_stall_cnt[15:0]), 32'd0);
      chk("stat flush", 32'(stat_flush_cnt), 32'd0);
`endif

      t.rst = 0; t.v = 0; t.br = 0; t.tk = 0; t.g = 0; t.cv = 0; t.cu = -1;
      t.cbr = 0; t.cbt = 0; t.busy = 0;
      apply(t, 999);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
